datapath_arbiter: RTL and testbench

Round-robin controller that shares one Start/Done datapath (4-bit `DataIn`, 4-bit `Out`) among `N_REQ` requesters. It selects a requester, presents that requester's operand, and pulses Start for one cycle. It then waits for Done, or a watchdog timeout, and returns the captured result with a one-cycle acknowledge to the granted requester. It sits between the requesting blocks and the datapath top, which is otherwise unchanged.

---
 rtl/datapath_arbiter_if.sv | 28 ++
 rtl/datapath_arbiter.sv | 160 ++++++++++++++++
 tb/tb_datapath_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_arbiter_if.sv
// Bundle of requester-side and datapath-side signals for datapath_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface datapath_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 4
);
    logic [N_REQ-1:0]    Req;
    logic [N_REQ*DW-1:0] ReqData;
    logic [N_REQ-1:0]    Grant;
    logic [N_REQ-1:0]    Ack;
    logic [DW-1:0]       Result;
    logic                Err;
    logic                Busy;
    logic                DP_Start;
    logic [DW-1:0]       DP_DataIn;
    logic                DP_Done;
    logic [DW-1:0]       DP_Out;

    modport slave (
        input  Req, ReqData, DP_Done, DP_Out,
        output Grant, Ack, Result, Err, Busy, DP_Start, DP_DataIn
    );

    modport master (
        output Req, ReqData, DP_Done, DP_Out,
        input  Grant, Ack, Result, Err, Busy, DP_Start, DP_DataIn
    );
endinterface

// File: rtl/datapath_arbiter.sv
// Round-robin sharing of one Start/Done datapath among N_REQ requesters,
// with a Done-masking guard cycle and a watchdog that aborts hung jobs.
module datapath_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 4,
    parameter int TIMEOUT = 255
) (
    input logic               CLK,
    input logic               RST_N,
    datapath_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state, state_next;
    logic [IW-1:0]     ptr, ptr_next;
    logic [IW-1:0]     idx, idx_next;
    logic [TW-1:0]     timer, timer_next;
    logic [N_REQ-1:0]  grant, grant_next;
    logic [N_REQ-1:0]  ack, ack_next;
    logic [DW-1:0]     result, result_next;
    logic [DW-1:0]     data, data_next;
    logic              err, err_next;
    logic              busy, busy_next;
    logic              start, start_next;

    logic              found;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     cand_idx;
    logic [DW-1:0]     pick_data;
    int                cand;

    // First set request bit at or above ptr, wrapping around.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        cand      = 0;
        cand_idx  = '0;
        pick_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IW'(cand);
            if (!found && bus.Req[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (IW'(j) == pick) begin
                pick_data = bus.ReqData[j*DW +: DW];
            end
        end
    end

    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        idx_next    = idx;
        timer_next  = timer;
        grant_next  = grant;
        ack_next    = '0;
        result_next = result;
        err_next    = err;
        data_next   = data;
        busy_next   = busy;
        start_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    idx_next   = pick;
                    data_next  = pick_data;
                    grant_next = N_REQ'(1) << pick;
                    start_next = 1'b1;
                    busy_next  = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_next = '0;
                state_next = S_GUARD;
            end
            // Done is deliberately not looked at here: it may still be high from the last job.
            S_GUARD: begin
                timer_next = timer + 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.DP_Done) begin
                    result_next = bus.DP_Out;
                    err_next    = 1'b0;
                    ack_next    = grant;
                    state_next  = S_RESP;
                end else if (timer == TW'(TIMEOUT)) begin
                    result_next = '0;
                    err_next    = 1'b1;
                    ack_next    = grant;
                    state_next  = S_RESP;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            S_RESP: begin
                grant_next = '0;
                busy_next  = 1'b0;
                ptr_next   = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= S_IDLE;
            ptr    <= '0;
            idx    <= '0;
            timer  <= '0;
            grant  <= '0;
            ack    <= '0;
            result <= '0;
            err    <= 1'b0;
            data   <= '0;
            busy   <= 1'b0;
            start  <= 1'b0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            idx    <= idx_next;
            timer  <= timer_next;
            grant  <= grant_next;
            ack    <= ack_next;
            result <= result_next;
            err    <= err_next;
            data   <= data_next;
            busy   <= busy_next;
            start  <= start_next;
        end
    end

    assign bus.Grant     = grant;
    assign bus.Ack       = ack;
    assign bus.Result    = result;
    assign bus.Err       = err;
    assign bus.Busy      = busy;
    assign bus.DP_Start  = start;
    assign bus.DP_DataIn = data;
endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter: reset, single job, round robin,
// stale Done masking, watchdog timeout and mid-job reset.
module tb_datapath_arbiter;
    localparam int N_REQ   = 4;
    localparam int DW      = 4;
    localparam int TIMEOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   check_count = 0;
    int   error_count = 0;

    datapath_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

    datapath_arbiter #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Datapath stand-in answers 3 cycles after Start with DataIn+1; manual mode overrides it.
    logic          model_done = 1'b0;
    logic [DW-1:0] model_out  = '0;
    int            since      = 0;
    bit            armed      = 1'b0;
    logic          manual_en   = 1'b0;
    logic          manual_done = 1'b0;
    logic [DW-1:0] manual_out  = '0;

    assign bus.DP_Done = manual_en ? manual_done : model_done;
    assign bus.DP_Out  = manual_en ? manual_out  : model_out;

    always @(negedge clk) begin
        if (!rst_n) begin
            armed      = 1'b0;
            model_done = 1'b0;
        end else if (bus.DP_Start === 1'b1) begin
            armed      = 1'b1;
            since      = 0;
            model_done = 1'b0;
        end else if (armed) begin
            since++;
            if (since == 3) begin
                model_done = 1'b1;
                model_out  = bus.DP_DataIn + 4'd1;
                armed      = 1'b0;
            end
        end else begin
            model_done = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] req, input logic [N_REQ*DW-1:0] data);
        bus.Req     = req;
        bus.ReqData = data;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_grant"}, 32'(bus.Grant),     32'h0);
        checkOutput({tag, "_ack"},   32'(bus.Ack),       32'h0);
        checkOutput({tag, "_res"},   32'(bus.Result),    32'h0);
        checkOutput({tag, "_err"},   32'(bus.Err),       32'h0);
        checkOutput({tag, "_busy"},  32'(bus.Busy),      32'h0);
        checkOutput({tag, "_start"}, 32'(bus.DP_Start),  32'h0);
        checkOutput({tag, "_din"},   32'(bus.DP_DataIn), 32'h0);
    endtask

    task automatic waitGrant(output logic [N_REQ-1:0] g);
        int n;
        n = 0;
        g = '0;
        while (g == '0 && n < 30) begin
            stepCycle();
            n++;
            g = bus.Grant;
        end
        checkOutput("grant_seen", 32'(g != '0), 32'd1);
    endtask

    task automatic waitAck(output logic [N_REQ-1:0] a, output int steps);
        steps = 0;
        a     = '0;
        while (a == '0 && steps < 40) begin
            stepCycle();
            steps++;
            a = bus.Ack;
        end
        checkOutput("ack_seen", 32'(a != '0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_time_limit: simulation did not end");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        logic [N_REQ-1:0] g;
        logic [N_REQ-1:0] a;
        int               steps;
        logic [3:0]       rr_grant [6];
        logic [3:0]       rr_result [6];
        rr_grant  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        rr_result = '{4'd2, 4'd4, 4'd8, 4'd2, 4'd4, 4'd8};

        // Reset with all requests pending, then first grant goes to requester 0.
        applyStimulus(4'b1111, 16'h7531);
        repeat (3) stepCycle();
        checkAllZero("reset");
        rst_n = 1'b1;
        stepCycle();
        checkOutput("first_grant", 32'(bus.Grant), 32'h1);
        checkOutput("first_start", 32'(bus.DP_Start), 32'h1);
        checkOutput("first_busy", 32'(bus.Busy), 32'h1);
        applyStimulus(4'b0000, 16'h7531);
        waitAck(a, steps);
        checkOutput("first_ack", 32'(a), 32'h1);
        checkOutput("first_latency", 32'(steps), 32'd4);
        checkOutput("first_result", 32'(bus.Result), 32'd2);
        stepCycle();

        // Single job for requester 2; operand changes after IDLE must not matter.
        applyStimulus(4'b0100, 16'h7931);
        stepCycle();
        checkOutput("single_grant", 32'(bus.Grant), 32'h4);
        checkOutput("single_start", 32'(bus.DP_Start), 32'h1);
        checkOutput("single_din", 32'(bus.DP_DataIn), 32'd9);
        applyStimulus(4'b0000, 16'h7031);
        stepCycle();
        checkOutput("single_start_once", 32'(bus.DP_Start), 32'h0);
        checkOutput("single_din_hold", 32'(bus.DP_DataIn), 32'd9);
        waitAck(a, steps);
        checkOutput("single_ack", 32'(a), 32'h4);
        checkOutput("single_result", 32'(bus.Result), 32'd10);
        checkOutput("single_err", 32'(bus.Err), 32'h0);
        stepCycle();
        checkOutput("single_idle_busy", 32'(bus.Busy), 32'h0);
        checkOutput("single_idle_grant", 32'(bus.Grant), 32'h0);
        checkOutput("single_idle_ack", 32'(bus.Ack), 32'h0);

        // Round robin from ptr=0 with requesters 0,1,3 held.
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        applyStimulus(4'b1011, 16'h7531);
        for (int j = 0; j < 6; j++) begin
            waitGrant(g);
            checkOutput("rr_grant", 32'(g), 32'(rr_grant[j]));
            waitAck(a, steps);
            checkOutput("rr_ack", 32'(a), 32'(rr_grant[j]));
            checkOutput("rr_result", 32'(bus.Result), 32'(rr_result[j]));
        end
        applyStimulus(4'b0000, 16'h7531);
        stepCycle();

        // Stale Done held high through ISSUE and GUARD, new Done four cycles into WAIT.
        manual_en   = 1'b1;
        manual_done = 1'b1;
        manual_out  = 4'hE;
        applyStimulus(4'b0001, 16'h7531);
        stepCycle();
        checkOutput("stale_grant", 32'(bus.Grant), 32'h1);
        applyStimulus(4'b0000, 16'h7531);
        stepCycle();
        checkOutput("stale_guard_ack", 32'(bus.Ack), 32'h0);
        stepCycle();
        checkOutput("stale_wait_ack", 32'(bus.Ack), 32'h0);
        manual_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            stepCycle();
            checkOutput("stale_hold_ack", 32'(bus.Ack), 32'h0);
        end
        manual_done = 1'b1;
        manual_out  = 4'h6;
        stepCycle();
        manual_done = 1'b0;
        checkOutput("stale_ack", 32'(bus.Ack), 32'h1);
        checkOutput("stale_result", 32'(bus.Result), 32'h6);
        checkOutput("stale_err", 32'(bus.Err), 32'h0);
        stepCycle();

        // Watchdog: Done never comes; requester 2 waits its turn behind requester 1.
        applyStimulus(4'b0010, 16'h7531);
        stepCycle();
        checkOutput("to_grant", 32'(bus.Grant), 32'h2);
        applyStimulus(4'b0100, 16'h7531);
        waitAck(a, steps);
        checkOutput("to_ack", 32'(a), 32'h2);
        checkOutput("to_latency", 32'(steps), 32'(TIMEOUT + 2));
        checkOutput("to_err", 32'(bus.Err), 32'h1);
        checkOutput("to_result", 32'(bus.Result), 32'h0);
        waitGrant(g);
        checkOutput("to_next_grant", 32'(g), 32'h4);

        // Reset in WAIT kills the job; pending requests restart from ptr=0.
        applyStimulus(4'b0110, 16'h7531);
        stepCycle();
        stepCycle();
        rst_n     = 1'b0;
        manual_en = 1'b0;
        stepCycle();
        checkAllZero("midreset");
        rst_n = 1'b1;
        waitGrant(g);
        checkOutput("midreset_grant", 32'(g), 32'h2);
        applyStimulus(4'b0000, 16'h7531);
        waitAck(a, steps);
        checkOutput("midreset_ack", 32'(a), 32'h2);
        checkOutput("midreset_result", 32'(bus.Result), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end
endmodule
